// File: rtl/traffic_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_sequencer
// Purpose  : Eight-phase intersection controller. Steps N/S green, E/W green
//            and pedestrian walk through yellow and all-red clearances. Each
//            phase dwells for a parameterised number of prescaled ticks. N/S
//            green rests after its minimum time until a latched side-road or
//            pedestrian request exists.
// Ports    : clk_i           system clock, rising edge
//            reset_i         synchronous active-high reset
//            ped_req_i       pedestrian button (level or pulse)
//            ew_car_i        side-road vehicle sensor (level or pulse)
//            hold_i          freeze timers and transitions while high
//            phase_o[2:0]    current phase index, to the 3-to-8 decoder
//            phase_start_o   first cycle of each newly entered phase
//            ped_ack_o       first cycle of PED_WALK
//            remaining_o[7:0] ticks left in the current phase
// Revision : 1.0  initial release
// ============================================================================
module traffic_phase_sequencer #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned T_GREEN  = 6,
  parameter int unsigned T_YELLOW = 2,
  parameter int unsigned T_ALLRED = 1,
  parameter int unsigned T_WALK   = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       ped_req_i,
  input  logic       ew_car_i,
  input  logic       hold_i,
  output logic [2:0] phase_o,
  output logic       phase_start_o,
  output logic       ped_ack_o,
  output logic [7:0] remaining_o
);

  // A one-bit prescaler still works for TICK_DIV=1: it stays at 0 and every
  // cycle is a tick.
  localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    PED_WALK  = 3'd6,
    ALLRED_C  = 3'd7
  } phase_e;

  function automatic logic [7:0] dur(input phase_e p);
    logic [7:0] d;
    case (p)
      NS_GREEN, EW_GREEN:  d = 8'(T_GREEN);
      NS_YELLOW, EW_YELLOW: d = 8'(T_YELLOW);
      PED_WALK:            d = 8'(T_WALK);
      default:             d = 8'(T_ALLRED);
    endcase
    return d;
  endfunction

  // Successor of a phase; the two branch points look at the latched demand.
  function automatic phase_e succ(input phase_e p, input logic car, input logic ped);
    phase_e n;
    case (p)
      NS_GREEN:  n = NS_YELLOW;
      NS_YELLOW: n = ALLRED_A;
      ALLRED_A:  n = car ? EW_GREEN : PED_WALK;
      EW_GREEN:  n = EW_YELLOW;
      EW_YELLOW: n = ALLRED_B;
      ALLRED_B:  n = ped ? PED_WALK : NS_GREEN;
      PED_WALK:  n = ALLRED_C;
      default:   n = NS_GREEN;
    endcase
    return n;
  endfunction

  phase_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    rem_q, rem_d;
  logic          car_pend_q, car_pend_d;
  logic          ped_pend_q, ped_pend_d;
  logic          phase_start_q, phase_start_d;
  logic          ped_ack_q, ped_ack_d;

  logic   tick;
  logic   enter;
  phase_e nxt;

  assign tick = (presc_q == TICK_LAST);
  assign nxt  = succ(state_q, car_pend_q, ped_pend_q);

  always_comb begin
    enter   = 1'b0;
    state_d = state_q;
    rem_d   = rem_q;
    presc_d = presc_q;

    if (!hold_i) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (state_q == NS_GREEN) begin
        if (rem_q == 8'd0) begin
          // Resting: leave as soon as any demand is latched, not tick-aligned.
          enter = car_pend_q | ped_pend_q;
        end else if (tick) begin
          if (rem_q == 8'd1) begin
            enter = car_pend_q | ped_pend_q;
            if (!enter) begin
              rem_d = 8'd0;
            end
          end else begin
            rem_d = rem_q - 8'd1;
          end
        end
      end else if (tick) begin
        if (rem_q == 8'd1) begin
          enter = 1'b1;
        end else if (rem_q != 8'd0) begin
          rem_d = rem_q - 8'd1;
        end
      end

      if (enter) begin
        state_d = nxt;
        rem_d   = dur(nxt);
        presc_d = '0;
      end
    end

    // Clearing on entry beats a simultaneous set; a held level re-sets it
    // on the following edge.
    car_pend_d    = (car_pend_q | ew_car_i)  & ~(enter && (nxt == EW_GREEN));
    ped_pend_d    = (ped_pend_q | ped_req_i) & ~(enter && (nxt == PED_WALK));
    phase_start_d = enter;
    ped_ack_d     = enter && (nxt == PED_WALK);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= NS_GREEN;
      presc_q       <= '0;
      rem_q         <= 8'(T_GREEN);
      car_pend_q    <= 1'b0;
      ped_pend_q    <= 1'b0;
      phase_start_q <= 1'b0;
      ped_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      rem_q         <= rem_d;
      car_pend_q    <= car_pend_d;
      ped_pend_q    <= ped_pend_d;
      phase_start_q <= phase_start_d;
      ped_ack_q     <= ped_ack_d;
    end
  end

  assign phase_o       = state_q;
  assign phase_start_o = phase_start_q;
  assign ped_ack_o     = ped_ack_q;
  assign remaining_o   = rem_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_phase_sequencer
// Purpose  : Self-checking bench for traffic_phase_sequencer with
//            TICK_DIV=4, T_GREEN=3, T_YELLOW=2, T_ALLRED=1, T_WALK=2.
// Revision : 1.0  initial release
// ============================================================================
module tb_traffic_phase_sequencer;

  localparam int TD = 4;
  localparam int TG = 3;
  localparam int TY = 2;
  localparam int TA = 1;
  localparam int TW = 2;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       ped_req_i = 1'b0;
  logic       ew_car_i = 1'b0;
  logic       hold_i = 1'b0;
  logic [2:0] phase_o;
  logic       phase_start_o;
  logic       ped_ack_o;
  logic [7:0] remaining_o;

  always #5 clk = ~clk;

  traffic_phase_sequencer #(
    .TICK_DIV (TD),
    .T_GREEN  (TG),
    .T_YELLOW (TY),
    .T_ALLRED (TA),
    .T_WALK   (TW)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .ped_req_i     (ped_req_i),
    .ew_car_i      (ew_car_i),
    .hold_i        (hold_i),
    .phase_o       (phase_o),
    .phase_start_o (phase_start_o),
    .ped_ack_o     (ped_ack_o),
    .remaining_o   (remaining_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase plus count of non-held cycles spent in it.
  int m_phase = 0;
  int m_el    = 0;
  bit m_car   = 0;
  bit m_ped   = 0;
  bit m_ps    = 0;
  bit m_ack   = 0;

  function automatic int dur(input int p);
    case (p)
      0, 3:    return TG;
      1, 4:    return TY;
      6:       return TW;
      default: return TA;
    endcase
  endfunction

  function automatic int m_rem();
    int r;
    r = dur(m_phase) - m_el / TD;
    return (r < 0) ? 0 : r;
  endfunction

  task automatic model_edge(input bit r, input bit p, input bit e, input bit h);
    int nxt;
    bit go;
    if (r) begin
      m_phase = 0; m_el = 0; m_car = 0; m_ped = 0; m_ps = 0; m_ack = 0;
    end else begin
      go  = 0;
      nxt = m_phase;
      if (!h) begin
        if (m_phase == 0) go = (m_car || m_ped) && (m_el + 1 >= dur(0) * TD);
        else              go = (m_el + 1 == dur(m_phase) * TD);
        case (m_phase)
          0: nxt = 1;
          1: nxt = 2;
          2: nxt = m_car ? 3 : 6;
          3: nxt = 4;
          4: nxt = 5;
          5: nxt = m_ped ? 6 : 0;
          6: nxt = 7;
          default: nxt = 0;
        endcase
        if (go) begin
          m_phase = nxt;
          m_el    = 0;
        end else begin
          m_el++;
        end
      end
      m_car = (m_car || e) && !(go && nxt == 3);
      m_ped = (m_ped || p) && !(go && nxt == 6);
      m_ps  = go;
      m_ack = go && (nxt == 6);
    end
  endtask

  task automatic step(input bit r, input bit p, input bit e, input bit h);
    reset_i   = r;
    ped_req_i = p;
    ew_car_i  = e;
    hold_i    = h;
    @(posedge clk);
    model_edge(r, p, e, h);
    #1;
    check("model_phase",       phase_o,       m_phase);
    check("model_remaining",   remaining_o,   m_rem());
    check("model_phase_start", phase_start_o, m_ps);
    check("model_ped_ack",     ped_ack_o,     m_ack);
  endtask

  // Step with idle inputs until phase_o equals target; flags a timeout.
  task automatic wait_phase(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (phase_o != 3'(target) && n < budget) begin
      step(0, 0, 0, 0);
      n++;
    end
    if (phase_o != 3'(target)) check({name, "_timeout"}, 0, 1);
  endtask

  typedef struct {
    bit r, p, e, h;
    int ph, rem;
    bit ps, ack;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input bit r, input bit p, input bit e, input bit h,
                     input int ph, input int rem, input bit ps, input bit ack);
    vec_t v;
    v.r = r; v.p = p; v.e = e; v.h = h; v.ph = ph; v.rem = rem; v.ps = ps; v.ack = ack;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  initial begin
    int cnt;
    int ps_seen;
    int prev;
    bit ok;

    // Reset, one pedestrian pulse: NS 12 cycles, yellow 8, all-red 4, walk.
    add(1, 1, 0, 0, 0, 0, 3, 0, 0);
    add(1, 0, 1, 0, 0, 0, 3, 0, 0);
    add(2, 0, 0, 0, 0, 0, 3, 0, 0);
    add(4, 0, 0, 0, 0, 0, 2, 0, 0);
    add(4, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 1, 2, 1, 0);
    add(3, 0, 0, 0, 0, 1, 2, 0, 0);
    add(4, 0, 0, 0, 0, 1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 2, 1, 1, 0);
    add(3, 0, 0, 0, 0, 2, 1, 0, 0);
    add(1, 0, 0, 0, 0, 6, 2, 1, 1);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].p, tbl[i].e, tbl[i].h);
      check($sformatf("tbl%0d_phase", i), phase_o, tbl[i].ph);
      check($sformatf("tbl%0d_rem", i),   remaining_o, tbl[i].rem);
      check($sformatf("tbl%0d_ps", i),    phase_start_o, tbl[i].ps);
      check($sformatf("tbl%0d_ack", i),   ped_ack_o, tbl[i].ack);
    end

    // Idle: N/S green rests with remaining 0 and no phase_start.
    step(1, 0, 0, 0);
    ps_seen = 0;
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 0, 0);
      if (phase_start_o) ps_seen++;
    end
    check("idle_phase", phase_o, 0);
    check("idle_rem", remaining_o, 0);
    check("idle_ps_count", ps_seen, 0);

    // Late pedestrian while resting: phase 1 one edge after the flag edge.
    step(0, 1, 0, 0);
    check("late_ped_still_ns", phase_o, 0);
    step(0, 0, 0, 0);
    check("late_ped_yellow", phase_o, 1);
    check("late_ped_ps", phase_start_o, 1);

    // Hold in EW_GREEN: total 32 cycles, ped request during hold served.
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    wait_phase(3, 200, "hold_to_ew");
    cnt = 1;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0);
      if (phase_o == 3'd3) cnt++;
    end
    for (int i = 0; i < 20; i++) begin
      step(0, (i == 7), 0, 1);
      if (phase_o == 3'd3) cnt++;
      check("hold_rem_frozen", remaining_o, 2);
    end
    for (int i = 0; i < 40 && phase_o == 3'd3; i++) begin
      step(0, 0, 0, 0);
      if (phase_o == 3'd3) cnt++;
    end
    check("hold_ew_length", cnt, 32);
    wait_phase(5, 100, "hold_to_allred_b");
    wait_phase(6, 20, "hold_ped_served");
    check("hold_walk_ack", ped_ack_o, 1);

    // Reset in PED_WALK with ew_car held high.
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    wait_phase(6, 200, "rst_to_walk");
    step(0, 0, 0, 0);
    step(1, 0, 1, 0);
    check("rst_phase", phase_o, 0);
    check("rst_rem", remaining_o, 3);
    check("rst_ack", ped_ack_o, 0);
    step(0, 0, 1, 0);
    ew_car_i = 1'b0;
    // car_pend survives, ped_pend was cleared: 0,1,2,3,4,5,0.
    prev = 0;
    ok = 1;
    cnt = 0;
    while (cnt < 200 && !(prev == 5 && phase_o == 3'd0)) begin
      prev = phase_o;
      step(0, 0, 0, 0);
      if (prev == 2 && phase_o == 3'd6) ok = 0;
      if (prev == 5 && phase_o == 3'd6) ok = 0;
      cnt++;
    end
    check("rst_seq_car_only", ok, 1);
    check("rst_seq_back_to_ns", phase_o, 0);

    // Randomised traffic against the reference model.
    step(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/traffic_phase_sequencer.md
# traffic_phase_sequencer

Phase controller for the traffic-light system: steps an 8-phase intersection cycle (main road N/S, side road E/W, pedestrian walk) using per-phase dwell timers derived from a prescaled tick. Its 3-bit `phase` output drives the 3-to-8 phase decoder, whose one-hot lines select the lamp pattern. Side-road and pedestrian service is demand-driven: N/S green rests indefinitely until a latched request exists.

## Interface

- `TICK_DIV`, 100_000_000 — clock cycles per dwell tick (1 s at 100 MHz); must be ≥1.
- `T_GREEN`, 6 — ticks in N/S green (minimum) and E/W green (fixed); 1..255.
- `T_YELLOW`, 2 — ticks in each yellow phase; 1..255.
- `T_ALLRED`, 1 — ticks in each all-red clearance phase; 1..255.
- `T_WALK`, 4 — ticks in pedestrian walk; 1..255.

- `clk`  in  1  system clock; everything is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ped_req`  in  1  pedestrian button, level or pulse; sampled every cycle.
- `ew_car`  in  1  side-road vehicle sensor, level or pulse.
- `hold`  in  1  freeze: timers and transitions stop while high.
- `phase`  out  3  current phase index, to the decoder.
- `phase_start`  out  1  high exactly on the first cycle of each newly entered phase.
- `ped_ack`  out  1  high on the first cycle of PED_WALK only.
- `remaining`  out  8  ticks left in the current phase.

## Operation

- Phases (encoding = `phase` value): 0 NS_GREEN, 1 NS_YELLOW, 2 ALLRED_A, 3 EW_GREEN, 4 EW_YELLOW, 5 ALLRED_B, 6 PED_WALK, 7 ALLRED_C.
- Durations: 0,3 → T_GREEN; 1,4 → T_YELLOW; 2,5,7 → T_ALLRED; 6 → T_WALK.
- Transitions: 0→1 (see below); 1→2; 2→3 if `car_pend` else 6; 3→4; 4→5; 5→6 if `ped_pend` else 0; 6→7; 7→0.
- Pending flags `car_pend`, `ped_pend`: registered; set by `ew_car` / `ped_req` high; cleared on the edge entering EW_GREEN / PED_WALK respectively. Set and clear on the same edge: clear wins (a held level re-sets the flag the following edge).
- Prescaler: counts 0..TICK_DIV-1; `tick` is combinational, high when count = TICK_DIV-1. Prescaler resets to 0 on every phase entry.
- `remaining` loaded with the new phase's duration on entry; decrements by 1 on each `tick`.
- Timed phases (1–7): transition on the edge where `tick` and `remaining`=1.
- NS_GREEN: at the expiry edge (`tick`, `remaining`=1), go to 1 if either flag is set; otherwise `remaining`→0 and stay. With `remaining`=0, go to 1 on the first edge where either registered flag is set (not tick-aligned).
- `hold`=1: prescaler, `remaining` and state frozen; flags continue to latch; `phase_start`/`ped_ack` low. Release resumes exactly where frozen.
- `phase_start`, `ped_ack` registered, asserted with the new `phase` value.
- 8-bit `remaining`, no wrap: never decrements below 0.

## Timing

- Reset values: `phase`=0, `remaining`=T_GREEN, `phase_start`=0, `ped_ack`=0, prescaler=0, both flags 0.
- Reset mid-phase overrides all: next cycle shows reset values regardless of `hold` or requests.
- Timed phase length: exactly duration×TICK_DIV cycles (hold cycles excluded).
- Request latency while resting in NS_GREEN with `remaining`=0: input high at edge N sets flag; `phase`=1 from edge N+1.
- TICK_DIV=1: tick every cycle; phase length = duration cycles.

## Test plan

Parameters for all: TICK_DIV=4, T_GREEN=3, T_YELLOW=2, T_ALLRED=1, T_WALK=2.
- Idle: reset, no requests for 100 cycles → `phase`=0 throughout; `remaining` 3,2,1 each for 4 cycles, then 0 held; `phase_start` never high.
- Car only: `ew_car` pulse 1 cycle after reset → phases 0,1,2,3,4,5,0 lasting 12,8,4,12,8,4 cycles; `phase_start` one pulse per entry; `ped_ack` never high.
- Both requests before NS expiry → sequence 0,1,2,3,4,5,6,7,0; PED_WALK lasts 8 cycles; `ped_ack` single cycle coincident with its `phase_start`; both flags 0 afterwards.
- Late pedestrian: `ped_req` 1-cycle pulse at cycle 40 (NS resting) → `phase`=1 at cycle 42; then 2, 6, 7, 0 (EW skipped).
- Hold: assert `hold` for 20 cycles, 5 cycles into EW_GREEN → `phase`=3 and `remaining` frozen; EW_GREEN totals 32 cycles; a `ped_req` during hold is served in that cycle's 5→6 transition.
- Reset mid-PED_WALK with `ew_car` held high → next cycle `phase`=0, `remaining`=3, `ped_ack`=0, `ped_pend`=0; `car_pend`=1 the following cycle.
